// File: rtl/delay_seq_pkg.sv
// delay_seq_pkg
//   Shared types and helpers for the multi-channel enable sequencer.
//   state_e   : sequencer state encoding (IDLE, UP, ON, DOWN)
//   idx_width : width of a channel index, never less than one bit
package delay_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_e;

    localparam int MIN_IDX_W = 1;

    // A single-channel build still needs a 1-bit index to keep every
    // select and compare well formed.
    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : MIN_IDX_W;
    endfunction

endpackage

// File: rtl/delay_seq_if.sv
// delay_seq_if
//   Request/status bundle between the power/clock controller and the
//   enable sequencer.
//   en_i   : 1 = sequence channels on, 0 = sequence them off
//   dly_i  : per-channel delay in rtc ticks, slice k is channel k
//   en_o   : channel enables (always a low-order contiguous mask)
//   busy_o : sequencing in progress
//   done_o : all channels enabled
//   master : controller side, slave : sequencer side
interface delay_seq_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                    en_i;
    logic [NUM_CH*CNT_W-1:0] dly_i;
    logic [NUM_CH-1:0]       en_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        output en_i,
        output dly_i,
        input  en_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  en_i,
        input  dly_i,
        output en_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/rtc_sync_edge.sv
// rtc_sync_edge
//   Brings an asynchronous timebase into the clk_i domain and turns each
//   rising edge into a single-cycle tick.
//   clk_i   : destination clock
//   arst_i  : asynchronous active-high reset
//   async_i : asynchronous timebase input
//   tick_o  : one-cycle pulse per rising edge of async_i
module rtc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic async_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced_q;
    logic                   synced_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
        synced_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q   <= '0;
            synced_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            synced_q <= synced_d;
        end
    end

    // Both terms come straight from flops, so the pulse is glitch free.
    assign tick_o = sync_q[SYNC_STAGES-1] & ~synced_q;

endmodule

// File: rtl/delay_seq.sv
// delay_seq
//   Sequences NUM_CH enables on in order 0..NUM_CH-1 with a programmable
//   rtc-tick delay before each channel, and off in reverse order using the
//   same delays. Delays are latched when a power-up starts.
//   clk_i  : block clock
//   arst_i : asynchronous active-high reset (released synchronously)
//   rtc_i  : asynchronous timebase, one tick per rising edge
//   bus    : delay_seq_if slave (en_i, dly_i, en_o, busy_o, done_o)
//
//   state | meaning
//   IDLE  | all channels off, waiting for en_i
//   UP    | counting ticks before enabling channel idx
//   ON    | all channels on
//   DOWN  | counting ticks before disabling channel idx
module delay_seq
    import delay_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        rtc_i,
    delay_seq_if.slave  bus
);

    localparam int                IDX_W    = idx_width(NUM_CH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    // Reset: asserts immediately, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst = rst_sync_q[1];

    logic tick;

    rtc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rtc_sync_edge (
        .clk_i   (clk_i),
        .arst_i  (rst),
        .async_i (rtc_i),
        .tick_o  (tick)
    );

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q,   idx_d;
    logic [CNT_W-1:0]               cnt_q,   cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   dly_q,   dly_d;
    logic [NUM_CH-1:0]              en_q,    en_d;
    logic                           busy_q,  busy_d;
    logic                           done_q,  done_d;

    logic [CNT_W-1:0] cur_dly;
    logic             step_done;

    assign cur_dly   = dly_q[idx_q];
    assign step_done = (cnt_q == cur_dly);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dly_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A request change always wins over a step completing in the same
    // cycle; a tick landing on a completion is absorbed, not carried.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        en_d    = en_q;

        case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    state_d = UP;
                    idx_d   = '0;
                    cnt_d   = '0;
                    dly_d   = bus.dly_i;
                end
            end

            UP: begin
                if (!bus.en_i) begin
                    cnt_d = '0;
                    // Channels 0..idx-1 are on; unwind from the highest.
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DOWN;
                        idx_d   = idx_q - IDX_W'(1);
                    end
                end else if (step_done) begin
                    en_d[idx_q] = 1'b1;
                    cnt_d       = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ON;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ON: begin
                if (!bus.en_i) begin
                    state_d = DOWN;
                    idx_d   = LAST_IDX;
                    cnt_d   = '0;
                end
            end

            DOWN: begin
                if (bus.en_i) begin
                    cnt_d = '0;
                    // Channels 0..idx are still on; resume at idx+1.
                    if (idx_q == LAST_IDX) begin
                        state_d = ON;
                    end else begin
                        state_d = UP;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (step_done) begin
                    en_d[idx_q] = 1'b0;
                    cnt_d       = '0;
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status is registered from the next state so it lines up with
    // state_q without a combinational path to the pins.
    always_comb begin
        busy_d = (state_d == UP) || (state_d == DOWN);
        done_d = (state_d == ON);
    end

    assign bus.en_o   = en_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

    a_en_contiguous: assert property (
        @(posedge clk_i) disable iff (rst)
        ((en_q + NUM_CH'(1)) & en_q) == '0
    );

    a_en_one_step: assert property (
        @(posedge clk_i) disable iff (rst)
        $countones(en_q ^ $past(en_q)) <= 1
    );

endmodule

// File: tb/tb_delay_seq.sv
module tb_delay_seq;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b0;
    logic rtc_i  = 1'b0;

    delay_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    delay_seq #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .rtc_i  (rtc_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: number of channels on, whether a sequence is in
    // flight and in which direction, ticks waited on the current step,
    // and the delays captured at the start of the last power-up.
    int m_on;
    bit m_active;
    bit m_rising;
    int m_wait;
    int m_dly [NUM_CH];
    bit hist  [SYNC_STAGES+1];
    bit m_tick;
    bit m_en;

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            m_on     = 0;
            m_active = 0;
            m_rising = 0;
            m_wait   = 0;
            for (int k = 0; k < NUM_CH; k++) m_dly[k] = 0;
            for (int k = 0; k <= SYNC_STAGES; k++) hist[k] = 0;
        end else begin
            // rtc_i sampled SYNC_STAGES edges ago, rising vs the sample before.
            m_tick = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES];
            m_en   = bus.en_i;
            for (int k = SYNC_STAGES; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = rtc_i;

            if (!m_active) begin
                if (m_on == 0 && m_en) begin
                    for (int k = 0; k < NUM_CH; k++) m_dly[k] = int'(bus.dly_i[k*CNT_W +: CNT_W]);
                    m_active = 1;
                    m_rising = 1;
                    m_wait   = 0;
                end else if (m_on == NUM_CH && !m_en) begin
                    m_active = 1;
                    m_rising = 0;
                    m_wait   = 0;
                end
            end else if (m_rising) begin
                if (!m_en) begin
                    m_wait = 0;
                    if (m_on == 0) m_active = 0;
                    else           m_rising = 0;
                end else if (m_wait == m_dly[m_on]) begin
                    m_on++;
                    m_wait = 0;
                    if (m_on == NUM_CH) m_active = 0;
                end else if (m_tick) begin
                    m_wait++;
                end
            end else begin
                if (m_en) begin
                    m_wait   = 0;
                    m_rising = 1;
                    if (m_on == NUM_CH) m_active = 0;
                end else if (m_wait == m_dly[m_on-1]) begin
                    m_on--;
                    m_wait = 0;
                    if (m_on == 0) m_active = 0;
                end else if (m_tick) begin
                    m_wait++;
                end
            end
        end
    end

    bit rtc_rand = 0;
    bit rtc_hold = 0;
    int rtc_ph   = 0;

    task automatic cycle();
        logic [NUM_CH-1:0] e;
        @(negedge clk_i);
        e = bus.en_o;
        chk("en_o",   32'(bus.en_o), 32'((1 << m_on) - 1));
        chk("busy_o", 32'(bus.busy_o), 32'(m_active));
        chk("done_o", 32'(bus.done_o), 32'(!m_active && m_on == NUM_CH));
        chk("en_contig", 32'(((e + NUM_CH'(1)) & e) == '0), 32'd1);
        if (rtc_hold) begin
            rtc_i = 1'b0;
        end else if (rtc_rand) begin
            rtc_i = 1'($urandom_range(0, 1));
        end else begin
            rtc_ph = (rtc_ph + 1) % 10;
            rtc_i  = (rtc_ph < 5);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_for(input string tag, input int on_t, input bit act_t,
                            input bit rise_t, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_on == on_t && m_active == act_t && (!act_t || m_rising == rise_t)) begin
                hit = 1;
                break;
            end
            cycle();
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        bus.en_i  = 1'b0;
        bus.dly_i = '0;
        #1 arst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_en_o",   32'(bus.en_o),   32'd0);
        chk("rst_busy_o", 32'(bus.busy_o), 32'd0);
        chk("rst_done_o", 32'(bus.done_o), 32'd0);
        arst_i = 1'b0;
        run(4);

        // Power-up with {3,2,1,0}
        bus.dly_i = {8'd3, 8'd2, 8'd1, 8'd0};
        bus.en_i  = 1'b1;
        cycle();
        cycle();
        chk("up_ch0_fast", 32'(bus.en_o), 32'h1);
        wait_for("up_reach_on", 4, 0, 0, 2000);
        chk("up_done", 32'(bus.done_o), 32'd1);
        chk("up_busy", 32'(bus.busy_o), 32'd0);

        // Power-down
        bus.en_i = 1'b0;
        wait_for("down_reach_idle", 0, 0, 0, 2000);
        chk("down_busy", 32'(bus.busy_o), 32'd0);

        // Abort during power-up at 0011
        bus.en_i = 1'b1;
        wait_for("abort_up_at_0011", 2, 1, 1, 2000);
        bus.en_i = 1'b0;
        wait_for("abort_up_idle", 0, 0, 0, 2000);

        // Abort during power-down at 0111, then finish the power-up
        bus.en_i = 1'b1;
        wait_for("restart_on1", 4, 0, 0, 2000);
        bus.en_i = 1'b0;
        wait_for("down_at_0111", 3, 1, 0, 2000);
        bus.en_i  = 1'b1;
        bus.dly_i = {8'd5, 8'd5, 8'd5, 8'd5};
        wait_for("restart_on2", 4, 0, 0, 2000);
        bus.en_i = 1'b0;
        wait_for("restart_idle", 0, 0, 0, 2000);

        // Maximum delays
        bus.dly_i = {4{8'hFF}};
        bus.en_i  = 1'b1;
        wait_for("max_on", 4, 0, 0, 12000);
        bus.en_i = 1'b0;
        wait_for("max_idle", 0, 0, 0, 12000);

        // Zero delays: one channel per cycle
        bus.dly_i = '0;
        bus.en_i  = 1'b1;
        cycle();
        for (int i = 1; i <= NUM_CH; i++) begin
            cycle();
            chk("zero_step", 32'(bus.en_o), 32'((1 << i) - 1));
        end
        bus.en_i = 1'b0;
        wait_for("zero_idle", 0, 0, 0, 100);

        // Asynchronous reset in the middle of a power-up
        bus.dly_i = {8'd2, 8'd2, 8'd2, 8'd2};
        bus.en_i  = 1'b1;
        wait_for("arst_mid_up", 2, 1, 1, 2000);
        #2;
        rtc_hold = 1;
        rtc_i    = 1'b0;
        arst_i   = 1'b1;
        #1;
        chk("arst_en_o",   32'(bus.en_o),   32'd0);
        chk("arst_busy_o", 32'(bus.busy_o), 32'd0);
        bus.en_i = 1'b0;
        cycle();
        cycle();
        arst_i = 1'b0;
        run(4);
        rtc_hold  = 0;
        bus.dly_i = {8'd4, 8'd2, 8'd3, 8'd1};
        bus.en_i  = 1'b1;
        wait_for("arst_restart_on", 4, 0, 0, 2000);
        bus.en_i = 1'b0;
        wait_for("arst_restart_idle", 0, 0, 0, 2000);

        // Randomized requests, timebase and delay changes
        rtc_rand = 1;
        for (int t = 0; t < 40; t++) begin
            bus.en_i = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) begin
                bus.dly_i = $urandom() & 32'h0707_0707;
                cycle();
            end
        end
        bus.en_i = 1'b0;
        wait_for("rand_idle", 0, 0, 0, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
